// File: rtl/qnt_pkg.sv
// qnt_pkg: definitions shared by the FP32<->INTn quantize/dequantize paths.
//   - FP32 field widths and exponent bias
//   - QMAX derivation from the integer width
//   - FP32 field unpack and value-class decode
package qnt_pkg;

  localparam int QNT_FP_DATA_W   = 32;
  localparam int QNT_FP_MANT_W   = 23;
  localparam int QNT_FP_EXP_W    = 8;
  localparam int QNT_FP_EXP_BIAS = 127;
  localparam int QNT_BIT_NUM     = 8;

  // Value class of an FP32 operand; subnormals are flushed into CLS_ZERO.
  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_NAN  = 2'd2,
    CLS_INF  = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic                     sign;
    logic [QNT_FP_EXP_W-1:0]  expo;
    logic [QNT_FP_MANT_W-1:0] frac;
  } fp_fields_t;

  // Largest magnitude of a symmetric signed integer of bit_num bits.
  function automatic int qmax_of(input int bit_num);
    return (1 << (bit_num - 1)) - 1;
  endfunction

  function automatic fp_fields_t fp32_unpack(input logic [QNT_FP_DATA_W-1:0] w);
    return fp_fields_t'(w);
  endfunction

  function automatic fp_class_e fp32_class(input fp_fields_t f);
    if (f.expo == '0) return CLS_ZERO;
    if (f.expo == '1) return (f.frac != '0) ? CLS_NAN : CLS_INF;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/quantize_stream_if.sv
// quantize_stream_if: streaming bus of the quantizer.
//   Input side : in_valid/in_ready, x_i (FP32), mantissa_scale/exp_scale (scale S)
//   Output side: out_valid/out_ready, q_o (signed INTn), sat_o
// Handshake: a beat moves when valid & ready are both high on a rising clock
// edge; a producer holding valid without ready keeps its payload stable.
interface quantize_stream_if #(
  parameter int FP_DATA_W = qnt_pkg::QNT_FP_DATA_W,
  parameter int FP_MANT_W = qnt_pkg::QNT_FP_MANT_W,
  parameter int FP_EXP_W  = qnt_pkg::QNT_FP_EXP_W,
  parameter int BIT_NUM   = qnt_pkg::QNT_BIT_NUM
);
  logic                 in_valid;
  logic                 in_ready;
  logic [FP_DATA_W-1:0] x_i;
  logic [FP_MANT_W-1:0] mantissa_scale;
  logic [FP_EXP_W-1:0]  exp_scale;
  logic                 out_valid;
  logic                 out_ready;
  logic [BIT_NUM-1:0]   q_o;
  logic                 sat_o;

  modport master (
    output in_valid, x_i, mantissa_scale, exp_scale, out_ready,
    input  in_ready, out_valid, q_o, sat_o
  );

  modport slave (
    input  in_valid, x_i, mantissa_scale, exp_scale, out_ready,
    output in_ready, out_valid, q_o, sat_o
  );
endinterface

// File: rtl/qnt_round_sat.sv
// qnt_round_sat: combinational round/saturate stage.
//   p_i    : unsigned mantissa product P; real magnitude is P * 2^-sh
//   sh_i   : signed right-shift amount
//   sign_i : result sign
//   cls_i  : class of the x operand; szero_i: scale exponent was zero
//   q_o    : signed result in [-QMAX, +QMAX]; sat_o: result was clamped or Inf
module qnt_round_sat
  import qnt_pkg::*;
#(
  parameter int PW      = 48,
  parameter int SHW     = 11,
  parameter int BIT_NUM = QNT_BIT_NUM
) (
  input  logic                  sign_i,
  input  logic [PW-1:0]         p_i,
  input  logic signed [SHW-1:0] sh_i,
  input  fp_class_e             cls_i,
  input  logic                  szero_i,
  output logic [BIT_NUM-1:0]    q_o,
  output logic                  sat_o
);
  localparam int                 QMAX     = qmax_of(BIT_NUM);
  // Beyond this shift the magnitude is below 1/4 and always rounds to zero.
  localparam int                 SH_FLUSH = PW + 2;
  localparam logic [PW:0]        QMAX_W   = (PW+1)'(QMAX);
  localparam logic [BIT_NUM-1:0] QMAX_Q   = BIT_NUM'(QMAX);

  logic [SHW-1:0]     sh_u;
  logic [PW-1:0]      m_raw;
  logic [PW:0]        p_ext, g_mask, s_mask, m_rnd;
  logic               guard, sticky;
  logic [BIT_NUM-1:0] mag;
  logic               sat;

  // Only meaningful when 0 < sh_i < SH_FLUSH; other values are filtered below.
  assign sh_u   = sh_i;
  assign p_ext  = {1'b0, p_i};
  assign m_raw  = p_i >> sh_u;
  // Guard and sticky picked with shifted masks instead of variable part-selects.
  assign g_mask = (PW+1)'(1) << (sh_u - SHW'(1));
  assign s_mask = g_mask - (PW+1)'(1);
  assign guard  = |(p_ext & g_mask);
  assign sticky = |(p_ext & s_mask);
  // Round to nearest, ties to even.
  assign m_rnd  = {1'b0, m_raw} + (PW+1)'(guard & (sticky | m_raw[0]));

  always_comb begin
    mag = '0;
    sat = 1'b0;
    if (sh_i <= 0) begin
      sat = 1'b1;
    end else if (sh_i < SHW'(SH_FLUSH)) begin
      if (m_rnd > QMAX_W) sat = 1'b1;
      else                mag = m_rnd[BIT_NUM-1:0];
    end
    if (sat) mag = QMAX_Q;
    // Special operands override the arithmetic; a zero scale wins over Inf.
    if (cls_i == CLS_ZERO || cls_i == CLS_NAN || szero_i) begin
      mag = '0;
      sat = 1'b0;
    end else if (cls_i == CLS_INF) begin
      mag = QMAX_Q;
      sat = 1'b1;
    end
    q_o   = sign_i ? -mag : mag;
    sat_o = sat;
  end
endmodule

// File: rtl/quantize_stream.sv
// quantize_stream: 3-stage FP32 -> INTn quantizer, q = RNE(x * S) clamped to +/-QMAX.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : quantize_stream_if.slave (input beat x/S, output beat q/sat)
//   clr_stat   : synchronous clear of sat_cnt (wins over a same-cycle increment)
//   sat_cnt    : saturated results delivered, sticks at all-ones
// Stages: S0 decode register, S1 multiply/exponent register, S2 output register.
module quantize_stream
  import qnt_pkg::*;
#(
  parameter int FP_DATA_W   = QNT_FP_DATA_W,
  parameter int FP_MANT_W   = QNT_FP_MANT_W,
  parameter int FP_EXP_W    = QNT_FP_EXP_W,
  parameter int FP_EXP_BIAS = QNT_FP_EXP_BIAS,
  parameter int BIT_NUM     = QNT_BIT_NUM,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  quantize_stream_if.slave bus,
  input  logic             clr_stat,
  output logic [CNT_W-1:0] sat_cnt
);
  localparam int PW  = 2 * (FP_MANT_W + 1);
  localparam int SHW = FP_EXP_W + 3;

  // Stage registers
  logic                  v0_q, sx0_q, szero0_q;
  logic [FP_EXP_W-1:0]   ex0_q, es0_q;
  logic [FP_MANT_W:0]    mx0_q, ms0_q;
  fp_class_e             cls0_q;
  logic                  v1_q, sx1_q, szero1_q;
  logic [PW-1:0]         p1_q;
  logic signed [SHW-1:0] sh1_q;
  fp_class_e             cls1_q;
  logic                  out_valid_q, sat_q;
  logic [BIT_NUM-1:0]    q_q;
  logic [CNT_W-1:0]      sat_cnt_q;

  // Next-state / combinational values
  logic [FP_DATA_W-1:0]  x_w;
  fp_fields_t            x_f;
  logic [PW-1:0]         p1_d;
  logic signed [SHW-1:0] e1_d, sh1_d;
  logic [BIT_NUM-1:0]    q2_d;
  logic                  sat2_d;
  logic                  rdy_out, rdy1, rdy0;

  assign x_w = bus.x_i;
  assign x_f = fp32_unpack(x_w);

  assign p1_d  = PW'(mx0_q) * PW'(ms0_q);
  assign e1_d  = $signed({3'b000, ex0_q}) + $signed({3'b000, es0_q}) - SHW'(2 * FP_EXP_BIAS);
  assign sh1_d = SHW'(2 * FP_MANT_W) - e1_d;

  qnt_round_sat #(.PW(PW), .SHW(SHW), .BIT_NUM(BIT_NUM)) u_round_sat (
    .sign_i  (sx1_q),
    .p_i     (p1_q),
    .sh_i    (sh1_q),
    .cls_i   (cls1_q),
    .szero_i (szero1_q),
    .q_o     (q2_d),
    .sat_o   (sat2_d)
  );

  // A stage may load when it is empty or its content moves on this cycle.
  // in_ready depends only on state and out_ready, never on in_valid.
  assign rdy_out      = ~out_valid_q | bus.out_ready;
  assign rdy1         = ~v1_q | rdy_out;
  assign rdy0         = ~v0_q | rdy1;
  assign bus.in_ready = rdy0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q        <= 1'b0;
      sx0_q       <= 1'b0;
      szero0_q    <= 1'b0;
      ex0_q       <= '0;
      es0_q       <= '0;
      mx0_q       <= '0;
      ms0_q       <= '0;
      cls0_q      <= CLS_ZERO;
      v1_q        <= 1'b0;
      sx1_q       <= 1'b0;
      szero1_q    <= 1'b0;
      p1_q        <= '0;
      sh1_q       <= '0;
      cls1_q      <= CLS_ZERO;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      sat_q       <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      if (rdy0) begin
        v0_q <= bus.in_valid;
        if (bus.in_valid) begin
          sx0_q    <= x_f.sign;
          ex0_q    <= x_f.expo;
          mx0_q    <= {1'b1, x_f.frac};
          es0_q    <= bus.exp_scale;
          ms0_q    <= {1'b1, bus.mantissa_scale};
          cls0_q   <= fp32_class(x_f);
          szero0_q <= (bus.exp_scale == '0);
        end
      end
      if (rdy1) begin
        v1_q <= v0_q;
        if (v0_q) begin
          sx1_q    <= sx0_q;
          p1_q     <= p1_d;
          sh1_q    <= sh1_d;
          cls1_q   <= cls0_q;
          szero1_q <= szero0_q;
        end
      end
      if (rdy_out) begin
        out_valid_q <= v1_q;
        if (v1_q) begin
          q_q   <= q2_d;
          sat_q <= sat2_d;
        end
      end
      if (clr_stat) begin
        sat_cnt_q <= '0;
      end else if (out_valid_q && bus.out_ready && sat_q && (sat_cnt_q != '1)) begin
        sat_cnt_q <= sat_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.q_o       = q_q;
  assign bus.sat_o     = sat_q;
  assign sat_cnt       = sat_cnt_q;
endmodule

// File: tb/tb_quantize_stream.sv
// tb_quantize_stream: randomized and directed bench for quantize_stream with a
// real-arithmetic reference model and an in-order expected queue.
module tb_quantize_stream;
  import qnt_pkg::*;

  localparam int CNT_W = 16;

  typedef struct {
    logic [31:0] x;
    logic [22:0] ms;
    logic [7:0]  es;
    logic        has_exp;
    logic [8:0]  e;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr_stat;
  logic [CNT_W-1:0] sat_cnt;

  quantize_stream_if bus ();

  quantize_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr_stat (clr_stat),
    .sat_cnt  (sat_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  beat_t      stim_q[$];
  logic [8:0] exp_q[$];       // {sat, q}
  int         acc_cyc_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         exp_cnt  = 0;
  int         acc_cnt  = 0;
  int         p_valid  = 100;
  int         p_ready  = 100;
  logic       clr_req  = 1'b0;
  logic       rnd_clr  = 1'b0;
  logic       lat_chk  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r * 0.5;
    return r;
  endfunction

  // Exact value x*S as a real, rounded half-to-even, clamped to +/-127.
  function automatic logic [8:0] ref_q(input logic [31:0] x, input logic [22:0] ms,
                                       input logic [7:0] es);
    int   ex, m;
    real  mag, fl, fr;
    logic s, sat;
    ex = int'(x[30:23]);
    s  = x[31];
    if (es == 8'd0 || ex == 0 || (ex == 255 && x[22:0] != 23'd0)) return 9'd0;
    if (ex == 255) return s ? 9'h181 : 9'h17F;
    mag = real'({1'b1, x[22:0]}) * real'({1'b1, ms}) * pow2(ex + int'(es) - 254 - 46);
    sat = 1'b0;
    if (mag >= 127.5) begin
      m   = 127;
      sat = 1'b1;
    end else begin
      fl = $floor(mag);
      fr = mag - fl;
      m  = int'(fl);
      if (fr > 0.5 || (fr == 0.5 && (m % 2) == 1)) m = m + 1;
    end
    return {sat, s ? 8'(-m) : 8'(m)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic push_dir(input logic [31:0] x, input logic [31:0] s, input logic [8:0] e);
    beat_t b;
    b.x = x; b.ms = s[22:0]; b.es = s[30:23]; b.has_exp = 1'b1; b.e = e;
    stim_q.push_back(b);
  endtask

  task automatic push_model(input logic [31:0] x, input logic [31:0] s);
    beat_t b;
    b.x = x; b.ms = s[22:0]; b.es = s[30:23]; b.has_exp = 1'b0; b.e = 9'd0;
    stim_q.push_back(b);
  endtask

  function automatic beat_t rand_beat();
    beat_t       b;
    logic [7:0]  ex;
    logic [22:0] fr;
    int          sel;
    sel = $urandom_range(0, 19);
    fr  = 23'($urandom);
    if ($urandom_range(0, 3) == 0) fr = fr & 23'h7F0000;
    if (sel == 0) ex = 8'd0;
    else if (sel == 1) begin
      ex = 8'hFF;
      if ($urandom_range(0, 1) == 0) fr = 23'd0;
    end else ex = 8'($urandom_range(112, 134));
    b.x  = {1'($urandom), ex, fr};
    b.ms = 23'($urandom);
    if ($urandom_range(0, 3) == 0) b.ms = b.ms & 23'h700000;
    b.es = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(118, 134));
    b.has_exp = 1'b0;
    b.e = 9'd0;
    return b;
  endfunction

  // ---------------- driver / monitor: one clock cycle ----------------
  task automatic run_cycle();
    logic       clr_now;
    logic [8:0] e_val;
    beat_t      b;
    @(negedge clk);
    cyc++;
    if (stim_q.size() > 0 && $urandom_range(0, 99) < p_valid) begin
      bus.in_valid       = 1'b1;
      bus.x_i            = stim_q[0].x;
      bus.mantissa_scale = stim_q[0].ms;
      bus.exp_scale      = stim_q[0].es;
    end else begin
      bus.in_valid       = 1'b0;
      bus.x_i            = $urandom;
      bus.mantissa_scale = 23'($urandom);
      bus.exp_scale      = 8'($urandom);
    end
    bus.out_ready = ($urandom_range(0, 99) < p_ready);
    clr_now  = clr_req | (rnd_clr && $urandom_range(0, 99) == 0);
    clr_stat = clr_now;
    #1;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", bus.out_valid, 0);
      end else if (bus.out_ready) begin
        e_val = exp_q.pop_front();
        check("q_sat", {bus.sat_o, bus.q_o}, e_val);
        if (lat_chk) check("latency", cyc - acc_cyc_q.pop_front(), 3);
        else void'(acc_cyc_q.pop_front());
        if (!clr_now && e_val[8] && exp_cnt < 65535) exp_cnt++;
      end else begin
        check("stall_hold", {bus.sat_o, bus.q_o}, exp_q[0]);
      end
    end
    if (clr_now) exp_cnt = 0;
    if (bus.in_valid && bus.in_ready) begin
      b = stim_q.pop_front();
      exp_q.push_back(b.has_exp ? b.e : ref_q(b.x, b.ms, b.es));
      acc_cyc_q.push_back(cyc);
      acc_cnt++;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      run_cycle();
      n++;
    end
    check("drain_done", stim_q.size() + exp_q.size(), 0);
    run_cycle();  // idle cycle: lets sat_cnt settle, catches extra outputs
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n              = 1'b0;
    clr_stat           = 1'b0;
    bus.in_valid       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.x_i            = '0;
    bus.mantissa_scale = '0;
    bus.exp_scale      = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_q", bus.q_o, 0);
    check("rst_sat", bus.sat_o, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // Directed values, back-to-back with latency checking.
    push_dir(32'h3FC00000, 32'h3F800000, 9'h002);  // 1.5 -> 2
    push_dir(32'h40200000, 32'h3F800000, 9'h002);  // 2.5 -> 2
    push_dir(32'h3F000000, 32'h3F800000, 9'h000);  // 0.5 -> 0
    push_dir(32'hC0400000, 32'h41200000, 9'h0E2);  // -3 * 10 -> -30
    push_dir(32'h3FC00000, 32'h42FE0000, 9'h17F);  // 190.5 -> clamp
    push_dir(32'hFF800000, 32'h3F800000, 9'h181);  // -Inf
    push_dir(32'h7FC00000, 32'h3F800000, 9'h000);  // NaN
    push_dir(32'h3FC00000, 32'h00400000, 9'h000);  // zero scale exponent
    push_dir(32'h42FF0000, 32'h3F800000, 9'h17F);  // 127.5 ties up to 128 -> clamp
    push_dir(32'h42FD0000, 32'h3F800000, 9'h07E);  // 126.5 -> 126
    push_dir(32'hC2FE0000, 32'h3F800000, 9'h081);  // -127, not clamped
    push_dir(32'h71800000, 32'h3F800000, 9'h17F);  // 2^100 -> clamp
    push_dir(32'h3A800000, 32'h3F800000, 9'h000);  // 2^-10 -> 0
    push_dir(32'h00000001, 32'h3F800000, 9'h000);  // subnormal flushed
    lat_chk = 1'b1;
    drain(200);
    lat_chk = 1'b0;
    check("sat_cnt_directed", sat_cnt, exp_cnt);

    // Backpressure: 6 beats (1,2,4,..,32), output stalled for 5 cycles.
    for (int i = 0; i < 6; i++) push_model({1'b0, 8'(127 + i), 23'd0}, 32'h3F800000);
    p_ready = 0;
    acc_cnt = 0;
    repeat (5) run_cycle();
    check("bp_accepted", acc_cnt, 3);
    check("bp_in_ready", bus.in_ready, 0);
    p_ready = 100;
    drain(100);

    // Random traffic against the model, with occasional counter clears.
    p_valid = 70;
    p_ready = 70;
    rnd_clr = 1'b1;
    for (int i = 0; i < 1000; i++) stim_q.push_back(rand_beat());
    drain(20000);
    rnd_clr = 1'b0;
    check("sat_cnt_random", sat_cnt, exp_cnt);

    // Clear held while a saturated beat is delivered.
    p_valid = 100;
    p_ready = 100;
    clr_req = 1'b1;
    push_dir(32'h7F800000, 32'h3F800000, 9'h17F);
    drain(50);
    clr_req = 1'b0;
    check("sat_cnt_clr", sat_cnt, 0);

    // Mid-stream reset with two beats in flight.
    push_dir(32'hFF800000, 32'h3F800000, 9'h181);
    drain(50);
    check("sat_cnt_pre_rst", sat_cnt, exp_cnt);
    push_model(32'h40400000, 32'h3F800000);
    push_model(32'h40800000, 32'h3F800000);
    p_ready = 0;
    repeat (4) run_cycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_sat_cnt", sat_cnt, 0);
    exp_q.delete();
    acc_cyc_q.delete();
    stim_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    p_ready = 100;
    lat_chk = 1'b1;
    push_dir(32'hC0A00000, 32'h3F800000, 9'h0FB);  // -5
    drain(50);
    lat_chk = 1'b0;
    check("sat_cnt_final", sat_cnt, exp_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
